// File: rtl/gf180mcu_osu_sc_clkgen_pkg.sv
// Shared types and helpers for the two-phase
// non-overlapping clock-phase generator.
package gf180mcu_osu_sc_clkgen_pkg;

  localparam int W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    P1,
    D1,
    P2,
    D2
  } state_e;

  // A programmed width of zero behaves as one cycle
  function automatic int unsigned max1(input int unsigned x);
    return (x == 0) ? 1 : x;
  endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_12T_clkgen_cnt.sv
// Loadable down-counter that parks at zero;
// paces every phase and dead-time interval.
module gf180mcu_osu_sc_12T_clkgen_cnt
  import gf180mcu_osu_sc_clkgen_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

  // Load wins; otherwise count down and hold at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (!zero) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gf180mcu_osu_sc_12t_clkgen_2ph.sv
// Two-phase non-overlapping phase-enable generator.
// PH1/PH2 come straight from flops to latch CLKN pins.
module gf180mcu_osu_sc_12t_clkgen_2ph
  import gf180mcu_osu_sc_clkgen_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic [W-1:0] PW1,
  input  logic [W-1:0] PW2,
  input  logic [W-1:0] DT,
  output logic         PH1,
  output logic         PH2,
  output logic         CYC_DONE,
  output logic         BUSY
);

  state_e state_q;
  state_e state_d;

  logic [W-1:0] sh_pw1_q;
  logic [W-1:0] sh_pw1_d;
  logic [W-1:0] sh_pw2_q;
  logic [W-1:0] sh_pw2_d;
  logic [W-1:0] sh_dt_q;
  logic [W-1:0] sh_dt_d;

  logic ph1_q;
  logic ph1_d;
  logic ph2_q;
  logic ph2_d;
  logic done_q;
  logic done_d;
  logic busy_q;
  logic busy_d;

  logic         cnt_load;
  logic [W-1:0] cnt_val;
  logic [W-1:0] cnt_count;
  logic         cnt_zero;

  // Interval length minus one, with zero read as one
  function automatic logic [W-1:0] ld(
    input logic [W-1:0] x
  );
    return W'(max1(32'(x)) - 32'd1);
  endfunction

  gf180mcu_osu_sc_12T_clkgen_cnt #(
    .W(W)
  ) u_cnt (
    .clk     (CLK),
    .rst     (RST),
    .load    (cnt_load),
    .load_val(cnt_val),
    .count   (cnt_count),
    .zero    (cnt_zero)
  );

  // State, shadow and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      sh_pw1_q <= '0;
      sh_pw2_q <= '0;
      sh_dt_q  <= '0;
      ph1_q    <= 1'b0;
      ph2_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_pw1_q <= sh_pw1_d;
      sh_pw2_q <= sh_pw2_d;
      sh_dt_q  <= sh_dt_d;
      ph1_q    <= ph1_d;
      ph2_q    <= ph2_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // Next state, config capture and counter reload
  always_comb begin
    state_d  = state_q;
    sh_pw1_d = sh_pw1_q;
    sh_pw2_d = sh_pw2_q;
    sh_dt_d  = sh_dt_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    unique case (state_q)
      IDLE: begin
        if (EN) begin
          state_d  = P1;
          sh_pw1_d = PW1;
          sh_pw2_d = PW2;
          sh_dt_d  = DT;
          cnt_load = 1'b1;
          cnt_val  = ld(PW1);
        end
      end
      P1: begin
        if (cnt_zero) begin
          state_d  = D1;
          cnt_load = 1'b1;
          cnt_val  = ld(sh_dt_q);
        end
      end
      D1: begin
        if (cnt_zero) begin
          state_d  = P2;
          cnt_load = 1'b1;
          cnt_val  = ld(sh_pw2_q);
        end
      end
      P2: begin
        if (cnt_zero) begin
          state_d  = D2;
          cnt_load = 1'b1;
          cnt_val  = ld(sh_dt_q);
        end
      end
      D2: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          if (EN) begin
            state_d  = P1;
            sh_pw1_d = PW1;
            sh_pw2_d = PW2;
            sh_dt_d  = DT;
            cnt_val  = ld(PW1);
          end else begin
            state_d = IDLE;
            cnt_val = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs decoded from the upcoming state
  always_comb begin
    ph1_d  = 1'b0;
    ph2_d  = 1'b0;
    busy_d = 1'b1;
    unique case (1'b1)
      (state_d == IDLE): busy_d = 1'b0;
      (state_d == P1):   ph1_d  = 1'b1;
      (state_d == P2):   ph2_d  = 1'b1;
      default:           ;
    endcase
    done_d = 1'b0;
    if (state_d == D2) begin
      done_d = cnt_load ? (cnt_val == '0)
                        : (cnt_count == W'(1));
    end
  end

  assign PH1      = ph1_q;
  assign PH2      = ph2_q;
  assign CYC_DONE = done_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_clkgen_2ph.sv
// Scoreboard bench for the two-phase generator:
// a cycle-plan model feeds expectations to a monitor.
module tb_gf180mcu_osu_sc_12t_clkgen_2ph;

  logic       CLK;
  logic       RST;
  logic       EN;
  logic [7:0] PW1;
  logic [7:0] PW2;
  logic [7:0] DT;
  logic       PH1;
  logic       PH2;
  logic       CYC_DONE;
  logic       BUSY;

  int errors = 0;
  int checks = 0;

  logic [3:0] plan[$];
  logic [3:0] sb[$];

  gf180mcu_osu_sc_12t_clkgen_2ph #(
    .W(8)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .EN      (EN),
    .PW1     (PW1),
    .PW2     (PW2),
    .DT      (DT),
    .PH1     (PH1),
    .PH2     (PH2),
    .CYC_DONE(CYC_DONE),
    .BUSY    (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int mx(input int x);
    return (x == 0) ? 1 : x;
  endfunction

  // Model: a whole cycle is planned when the previous one ends.
  // Entry bits are {PH1, PH2, CYC_DONE, BUSY}.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      plan.delete();
      sb.delete();
    end else begin
      if (plan.size() == 0) begin
        if (EN) begin
          int a;
          int b;
          int d;
          a = mx(int'(PW1));
          b = mx(int'(PW2));
          d = mx(int'(DT));
          for (int i = 0; i < a; i++) plan.push_back(4'b1001);
          for (int i = 0; i < d; i++) plan.push_back(4'b0001);
          for (int i = 0; i < b; i++) plan.push_back(4'b0101);
          for (int i = 0; i < d - 1; i++) plan.push_back(4'b0001);
          plan.push_back(4'b0011);
        end else begin
          plan.push_back(4'b0000);
        end
      end
      sb.push_back(plan.pop_front());
    end
  end

  // Monitor: compare after each edge, plus phase invariants
  always @(posedge CLK) begin
    logic b1;
    logic b2;
    logic [3:0] exp_v;
    b1 = PH1;
    b2 = PH2;
    #1;
    if (!RST) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: no expectation at %0t", $time);
      end else begin
        exp_v = sb.pop_front();
        if ({PH1, PH2, CYC_DONE, BUSY} !== exp_v) begin
          errors++;
          $display("FAIL outs: got %b want %b at %0t",
                   {PH1, PH2, CYC_DONE, BUSY}, exp_v, $time);
        end
      end
      checks++;
      if (PH1 && PH2) begin
        errors++;
        $display("FAIL overlap: PH1=%b PH2=%b want not both 1 at %0t",
                 PH1, PH2, $time);
      end
      checks++;
      if ((PH1 != b1) && (PH2 != b2)) begin
        errors++;
        $display("FAIL same_edge: PH1 %b->%b PH2 %b->%b at %0t",
                 b1, PH1, b2, PH2, $time);
      end
    end
  end

  task automatic check_zero(input string nm);
    checks++;
    if ({PH1, PH2, CYC_DONE, BUSY} !== 4'b0000) begin
      errors++;
      $display("FAIL %s: got %b want 0000", nm,
               {PH1, PH2, CYC_DONE, BUSY});
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    bit found;
    RST = 1'b1;
    EN  = 1'b0;
    PW1 = 8'd0;
    PW2 = 8'd0;
    DT  = 8'd0;
    #1;
    check_zero("reset_state");
    cyc(2);
    RST = 1'b0;

    // Basic run: period 7
    PW1 = 8'd3;
    PW2 = 8'd2;
    DT  = 8'd1;
    EN  = 1'b1;
    cyc(22);

    // Zero fields: period 4
    PW1 = 8'd0;
    PW2 = 8'd0;
    DT  = 8'd0;
    cyc(13);

    // EN drop mid-cycle
    EN  = 1'b0;
    cyc(6);
    PW1 = 8'd4;
    PW2 = 8'd2;
    DT  = 8'd2;
    EN  = 1'b1;
    cyc(2);
    EN  = 1'b0;
    cyc(20);
    check_zero("idle_after_drop");

    // Config change during P2
    PW1 = 8'd3;
    PW2 = 8'd3;
    DT  = 8'd1;
    EN  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge CLK);
      if (PH2) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_ph2: got timeout want PH2 within 40");
    end
    PW1 = 8'd6;
    cyc(24);

    // Async reset during P2
    EN  = 1'b0;
    cyc(16);
    PW1 = 8'd1;
    PW2 = 8'd5;
    DT  = 8'd1;
    EN  = 1'b1;
    cyc(4);
    checks++;
    if (PH2 !== 1'b1) begin
      errors++;
      $display("FAIL ph2_before_rst: got %b want 1", PH2);
    end
    #2;
    RST = 1'b1;
    #1;
    check_zero("async_reset");
    #1;
    RST = 1'b0;
    cyc(1);
    checks++;
    if (PH1 !== 1'b1) begin
      errors++;
      $display("FAIL restart_ph1: got %b want 1", PH1);
    end
    cyc(10);

    // Randomized run
    for (int i = 0; i < 10000; i++) begin
      @(negedge CLK);
      if ($urandom_range(0, 3) == 0) begin
        PW1 = 8'($urandom_range(0, 5));
        PW2 = 8'($urandom_range(0, 5));
        DT  = 8'($urandom_range(0, 3));
      end
      EN = ($urandom_range(0, 9) != 0);
    end
    cyc(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gf180mcu_osu_sc_12t_clkgen_2ph.md
# gf180mcu_osu_sc_12T_clkgen_2ph

Two-phase, non-overlapping clock-phase generator that drives the CLKN pins of `dlatn`-class latches in latch-based pipelines and characterization chains. It derives two mutually exclusive phase enables, PH1 and PH2, from one master clock, with programmable high widths and dead time. Each latch is transparent while its CLKN is high and captures on the falling edge, so the two latch ranks never run transparent at the same time. It sits directly upstream of the latch array.

## Interface
- `W`, 8: width of the width and dead-time count fields.
- `CLK`  in  1  master clock; all state changes occur on its rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `EN`  in  1  run request; sampled in IDLE and at the end of each cycle.
- `PW1`  in  W  PH1 high width, in CLK cycles; 0 is treated as 1.
- `PW2`  in  W  PH2 high width, in CLK cycles; 0 is treated as 1.
- `DT`  in  W  dead time between phases, in CLK cycles; 0 is treated as 1.
- `PH1`  out  1  phase-1 enable, driving CLKN of rank-1 latches; registered.
- `PH2`  out  1  phase-2 enable, driving CLKN of rank-2 latches; registered.
- `CYC_DONE`  out  1  one-cycle pulse on the last cycle of each full cycle.
- `BUSY`  out  1  high in every state except IDLE.

## Operation
- The FSM has five states: IDLE, P1, D1, P2, D2.
- IDLE: PH1=PH2=0.
  - EN=1 at a rising edge: the block latches PW1, PW2 and DT into shadow registers and enters P1.
  - Shadow values stay fixed for the whole cycle. Input changes mid-cycle take effect only at the next P1 entry.
- P1: PH1=1 for max(PW1,1) cycles, then D1.
- D1: both phases 0 for max(DT,1) cycles, then P2.
- P2: PH2=1 for max(PW2,1) cycles, then D2.
- D2: both phases 0 for max(DT,1) cycles.
  - CYC_DONE=1 on the last D2 cycle.
  - At that edge: EN=1 re-samples the config and enters P1; EN=0 enters IDLE.
- EN deassertion mid-cycle does not truncate the cycle. The block always completes through D2, so no latch sees a runt pulse.
- Invariant: PH1 and PH2 are never 1 in the same cycle, and never change on the same edge.
- A single down-counter loads (shadow value − 1, floored at 0) on each state entry and advances the state at 0.

## Timing
- Reset values: PH1=0, PH2=0, CYC_DONE=0, BUSY=0, state IDLE, counter 0, shadows 0.
- RST asserted mid-operation clears PH1, PH2 and the other outputs immediately, without waiting for CLK. After release, the block restarts from IDLE.
- Startup latency: EN sampled high at edge k puts PH1=1 from edge k (registered output, visible after k).
- Cycle period = max(PW1,1) + max(PW2,1) + 2·max(DT,1) CLK cycles.
- BUSY rises with PH1 on P1 entry and falls on the edge that enters IDLE.
- Outputs are direct flop outputs, glitch-free by construction. Nothing combinational sits between the flops and CLKN.

## Structure
- Shared package `gf180mcu_osu_sc_clkgen_pkg`:
  - state enum {IDLE, P1, D1, P2, D2};
  - default `W`;
  - helper function max1(x) implementing the zero-as-one rule.
- Sub-module `gf180mcu_osu_sc_12T_clkgen_cnt`: W-bit loadable down-counter with async active-high reset, a `load` input and a `zero` flag. The top level holds the FSM, shadows and output flops.

## Test plan
- Basic run: PW1=3, PW2=2, DT=1, EN=1 held from edge 0.
  - PH1 high on cycles 0–2, both low on 3, PH2 high on 4–5, both low on 6.
  - CYC_DONE on 6, PH1 high again on 7; period 7.
- Zero fields: PW1=PW2=DT=0 → PH1 1, gap 1, PH2 1, gap 1; period 4; CYC_DONE every 4th cycle.
- Mid-cycle EN drop: EN low during P1 → cycle completes through D2, then IDLE. PH1/PH2 stay 0 and BUSY=0 afterwards.
- Config change mid-cycle: PW1 changed 3→6 during P2 → current cycle unchanged, next PH1 width 6.
- Async reset during P2 (PW2=5): RST pulses between clock edges → PH2 drops at once, without a clock edge, and all outputs read 0. After release with EN=1, PH1 rises on the first sampled edge.
- Random PW1/PW2/DT/EN over 10k cycles with assertions:
  - PH1 and PH2 are never both 1, and never change on the same edge;
  - every high pulse is at least 1 cycle and matches its shadow width.
